adder_tree_acc: RTL

- Parametrised successor to the fixed 27-input conv adder tree.
- Sums NUM_INPUTS signed products plus a bias through a registered binary tree of arbitrary depth.
- Accumulates the tree result across multiple passes, so channel counts larger than one tile are handled by splitting them into passes.
- Requantizes the final sum by a fixed-point shift, rounds it and saturates it to the output width. Sits between the MAC array and the activation/writeback stage.

---
 rtl/adder_tree_acc_if.sv | 37 +++
 rtl/adder_tree_acc.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_acc_if.sv
`default_nettype none
// ============================================================================
//  Module      : adder_tree_acc_if
//  Description : Bus between the MAC array, the adder-tree accumulator and
//                the activation/writeback stage. Carries the packed signed
//                products, the bias and pass sidebands toward the tree, and
//                the requantized result strobe back out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adder_tree_acc_if #(
  parameter int BITSIZE    = 14,
  parameter int NUM_INPUTS = 27,
  parameter int BIAS_SIZE  = 14,
  parameter int OUT_BITS   = 8
);
  logic [NUM_INPUTS*BITSIZE-1:0] input_numbers;
  logic [BIAS_SIZE-1:0]          bias;
  logic                          in_valid;
  logic                          in_first;
  logic                          in_last;
  logic [OUT_BITS-1:0]           sum_output;
  logic                          data_valid;
  logic                          sat;

  // Upstream producer side
  modport master (
    output input_numbers, bias, in_valid, in_first, in_last,
    input  sum_output, data_valid, sat
  );

  // Adder-tree side
  modport slave (
    input  input_numbers, bias, in_valid, in_first, in_last,
    output sum_output, data_valid, sat
  );
endinterface
`default_nettype wire

// File: rtl/adder_tree_acc.sv
`default_nettype none
// ============================================================================
//  Module      : adder_tree_acc
//  Description : Registered binary adder tree over NUM_INPUTS signed products
//                plus a bias leaf, followed by a multi-pass accumulator and a
//                round-half-up / saturating requantizer.
//                Optional build macro: ADDER_TREE_RELU_EN (clips negative
//                rounded results to zero before saturation).
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_tree_acc #(
  parameter int BITSIZE    = 14,
  parameter int NUM_INPUTS = 27,
  parameter int BIAS_SIZE  = 14,
  parameter int FRAC_BITS  = 7,
  parameter int OUT_BITS   = 8,
  parameter int ACC_GUARD  = 4
) (
  input  logic           clk,
  input  logic           rst,
  adder_tree_acc_if.slave bus
);

  localparam int LEAF_W = (BITSIZE > BIAS_SIZE) ? BITSIZE : BIAS_SIZE;
  localparam int LEAVES = NUM_INPUTS + 1;
  localparam int LEVELS = $clog2(LEAVES);
  localparam int TREE_W = LEAF_W + LEVELS;
  localparam int ACC_W  = TREE_W + ACC_GUARD;
  localparam int RQ_W   = ACC_W + 1;   // one spare bit so adding the rounding constant cannot wrap

  // Number of nodes present at tree level k (level 0 = leaves)
  function automatic int nodes_at(input int k);
    int n;
    n = LEAVES;
    for (int i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction

  // Node offset of level k inside the flattened {registered levels, leaves} vector
  function automatic int lvl_base(input int k);
    int o;
    o = 0;
    for (int i = 0; i < k; i++) o += nodes_at(i);
    return o;
  endfunction

  localparam int ALL_NODES = lvl_base(LEVELS + 1);
  localparam int REG_NODES = ALL_NODES - LEAVES;

  localparam int                     RND_SH  = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic signed [RQ_W-1:0] RND_C   = (FRAC_BITS > 0) ? (RQ_W'(1) << RND_SH) : '0;
  localparam logic signed [RQ_W-1:0] OUT_MAX = RQ_W'((64'sd1 <<< (OUT_BITS - 1)) - 64'sd1);
  localparam logic signed [RQ_W-1:0] OUT_MIN = ~OUT_MAX;

  logic [LEAVES*TREE_W-1:0]    leaves;
  logic [REG_NODES*TREE_W-1:0] node_d, node_q;
  logic [ALL_NODES*TREE_W-1:0] all_nodes;
  logic [LEVELS:1]             vld_d, vld_q;
  logic [LEVELS:1]             first_d, first_q;
  logic [LEVELS:1]             last_d, last_q;
  logic signed [TREE_W-1:0]    tree_sum;
  logic                        tree_vld, tree_first, tree_last;
  logic signed [ACC_W-1:0]     acc_d, acc_q;
  logic                        rq_pend_d, rq_pend_q;
  logic signed [RQ_W-1:0]      rq_sum, rq_val;
  logic [OUT_BITS-1:0]         sum_output_d, sum_output_q;
  logic                        data_valid_d, data_valid_q;
  logic                        sat_d, sat_q;

  // Sign-extend every product to tree width; the bias leaf only contributes on a first pass
  always_comb begin
    leaves = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      leaves[i*TREE_W +: TREE_W] = TREE_W'($signed(bus.input_numbers[i*BITSIZE +: BITSIZE]));
    end
    if (bus.in_first) begin
      leaves[NUM_INPUTS*TREE_W +: TREE_W] = TREE_W'($signed(bus.bias));
    end
  end

  assign all_nodes = {node_q, leaves};
  assign tree_sum  = all_nodes[lvl_base(LEVELS)*TREE_W +: TREE_W];

  // Each level adds adjacent pairs of the level below; an odd last node passes straight through
  always_comb begin
    logic signed [TREE_W-1:0] a_node;
    logic signed [TREE_W-1:0] b_node;
    a_node = '0;
    b_node = '0;
    node_d = node_q;
    for (int k = 1; k <= LEVELS; k++) begin
      for (int j = 0; j < nodes_at(k); j++) begin
        a_node = all_nodes[(lvl_base(k-1) + 2*j)*TREE_W +: TREE_W];
        b_node = '0;
        if (2*j + 1 < nodes_at(k-1)) begin
          b_node = all_nodes[(lvl_base(k-1) + 2*j + 1)*TREE_W +: TREE_W];
        end
        node_d[(lvl_base(k) - LEAVES + j)*TREE_W +: TREE_W] = a_node + b_node;
      end
    end
  end

  // Valid/first/last shift register that travels alongside the tree levels
  always_comb begin
    vld_d      = vld_q;
    first_d    = first_q;
    last_d     = last_q;
    vld_d[1]   = bus.in_valid;
    first_d[1] = bus.in_first;
    last_d[1]  = bus.in_last;
    for (int k = 2; k <= LEVELS; k++) begin
      vld_d[k]   = vld_q[k-1];
      first_d[k] = first_q[k-1];
      last_d[k]  = last_q[k-1];
    end
  end

  assign tree_vld   = vld_q[LEVELS];
  assign tree_first = first_q[LEVELS];
  assign tree_last  = last_q[LEVELS];

  // Accumulator: load on a first pass, otherwise wrap-add; arm requant on the last pass
  always_comb begin
    acc_d     = acc_q;
    rq_pend_d = 1'b0;
    if (tree_vld) begin
      if (tree_first) begin
        acc_d = ACC_W'(tree_sum);
      end else begin
        acc_d = acc_q + ACC_W'(tree_sum);
      end
      rq_pend_d = tree_last;
    end
  end

  // Requantize: round half up, shift, optionally clip negatives, then saturate
  always_comb begin
    rq_sum = RQ_W'(acc_q) + RND_C;
    rq_val = rq_sum >>> FRAC_BITS;
`ifdef ADDER_TREE_RELU_EN
    if (rq_val < 0) begin
      rq_val = '0;
    end
`endif
    sum_output_d = sum_output_q;
    sat_d        = sat_q;
    data_valid_d = rq_pend_q;
    if (rq_pend_q) begin
      if (rq_val > OUT_MAX) begin
        sum_output_d = OUT_MAX[OUT_BITS-1:0];
        sat_d        = 1'b1;
      end else if (rq_val < OUT_MIN) begin
        sum_output_d = OUT_MIN[OUT_BITS-1:0];
        sat_d        = 1'b1;
      end else begin
        sum_output_d = rq_val[OUT_BITS-1:0];
        sat_d        = 1'b0;
      end
    end
  end

  // Tree partial sums: each level captures only when a valid beat enters it
  always_ff @(posedge clk) begin
    for (int k = 1; k <= LEVELS; k++) begin
      if (vld_d[k]) begin
        for (int j = 0; j < nodes_at(k); j++) begin
          node_q[(lvl_base(k) - LEAVES + j)*TREE_W +: TREE_W] <=
            node_d[(lvl_base(k) - LEAVES + j)*TREE_W +: TREE_W];
        end
      end
    end
  end

  // Control, accumulator and output registers; reset drops every in-flight beat
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q        <= '0;
      first_q      <= '0;
      last_q       <= '0;
      acc_q        <= '0;
      rq_pend_q    <= 1'b0;
      sum_output_q <= '0;
      data_valid_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      vld_q        <= vld_d;
      first_q      <= first_d;
      last_q       <= last_d;
      acc_q        <= acc_d;
      rq_pend_q    <= rq_pend_d;
      sum_output_q <= sum_output_d;
      data_valid_q <= data_valid_d;
      sat_q        <= sat_d;
    end
  end

  assign bus.sum_output = sum_output_q;
  assign bus.data_valid = data_valid_q;
  assign bus.sat        = sat_q;

endmodule
`default_nettype wire
